// File: rtl/lutram_pkg.sv
// rtl/lutram_pkg.sv - shared constants and helpers for the LUTRAM read port
package lutram_pkg;

  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_PTR_W      = 1;
  localparam int RSP_CNT_W      = 2;

  // Range check done on zero-extended values so a lower bound of 0 stays a
  // plain runtime comparison rather than a constant-true expression.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/lutram_rsp_fifo2.sv
// rtl/lutram_rsp_fifo2.sv - 2-entry response FIFO with 1-bit wrapping pointers
module lutram_rsp_fifo2
  import lutram_pkg::*;
#(
  parameter int width = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [width-1:0]     push_entry,
  input  logic                 pop,
  output logic [RSP_CNT_W-1:0] count,
  output logic [width-1:0]     head
);

  logic [width-1:0]     mem [RSP_FIFO_DEPTH];
  logic [RSP_PTR_W-1:0] rd_ptr;
  logic [RSP_PTR_W-1:0] wr_ptr;
  logic                 do_push;
  logic                 do_pop;

  // A full FIFO refuses pushes and an empty one ignores pops.
  assign do_push = push && (count != RSP_CNT_W'(RSP_FIFO_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; entries are cleared so the head reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lutram_read_port.sv
// rtl/lutram_read_port.sv - read request/response engine for the LUTRAM async port; optional LUTRAM_READ_BYPASS_EN
module lutram_read_port
  import lutram_pkg::*;
#(
  parameter int addr_width = 1,
  parameter int data_width = 1,
  parameter int lo         = 0,
  parameter int hi         = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  input  logic [addr_width-1:0] REQ_ADDR,
  output logic                  REQ_RDY,
  output logic                  RSP_VALID,
  output logic [data_width-1:0] RSP_DATA,
  output logic                  RSP_OOR,
  input  logic                  RSP_RDY,
  output logic [addr_width-1:0] RAM_ADDR,
  input  logic [data_width-1:0] RAM_DOUT,
  input  logic                  WR_EN,
  input  logic [addr_width-1:0] WR_ADDR,
  input  logic [data_width-1:0] WR_DATA
);

  typedef struct packed {
    logic                  oor;
    logic [data_width-1:0] data;
  } rsp_entry_t;

  localparam int ENTRY_W = $bits(rsp_entry_t);

  rsp_entry_t           push_entry;
  rsp_entry_t           head_entry;
  logic [ENTRY_W-1:0]   head_bits;
  logic [RSP_CNT_W-1:0] count;
  logic                 in_range;
  logic                 accept;
  logic [data_width-1:0] rd_data;

  // The RAM read is asynchronous, so the address goes straight through.
  assign RAM_ADDR = REQ_ADDR;
  assign in_range = addr_in_range(32'(REQ_ADDR), 32'(lo), 32'(hi));

  // Readiness depends only on FIFO occupancy, never on RSP_RDY.
  assign REQ_RDY  = !RST && (count != RSP_CNT_W'(RSP_FIFO_DEPTH));
  assign accept   = REQ_VALID && REQ_RDY;

`ifndef LUTRAM_READ_BYPASS_EN
  wire unused_wr_snoop = &{1'b0, WR_EN, WR_ADDR, WR_DATA};
`endif

  // Build the entry captured on the accepting edge: snapshot of the read, or 0 when out of range.
  always_comb begin
    rd_data = RAM_DOUT;
`ifdef LUTRAM_READ_BYPASS_EN
    if (WR_EN && (WR_ADDR == REQ_ADDR)) begin
      rd_data = WR_DATA;
    end
`endif
    push_entry.oor  = !in_range;
    push_entry.data = in_range ? rd_data : '0;
  end

  lutram_rsp_fifo2 #(
    .width (ENTRY_W)
  ) u_rsp_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (RSP_RDY),
    .count      (count),
    .head       (head_bits)
  );

  assign head_entry = rsp_entry_t'(head_bits);
  assign RSP_VALID  = (count != '0);
  assign RSP_DATA   = head_entry.data;
  assign RSP_OOR    = head_entry.oor;

endmodule

// File: tb/tb_lutram_read_port.sv
// tb/tb_lutram_read_port.sv - self-checking bench for lutram_read_port
module tb_lutram_read_port;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int HI = 15;
`ifdef LUTRAM_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk;
  logic          RST;
  logic          REQ_VALID;
  logic [AW-1:0] REQ_ADDR;
  logic          REQ_RDY;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_DATA;
  logic          RSP_OOR;
  logic          RSP_RDY;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DOUT;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;

  typedef struct {
    logic          oor;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] ram [32];
  exp_t          q[$];
  bit            loaded;
  bit            started;
  int            n_cmp;
  int            n_fail;

  lutram_read_port #(
    .addr_width (AW),
    .data_width (DW),
    .lo         (0),
    .hi         (HI)
  ) dut (
    .CLK       (clk),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_RDY   (REQ_RDY),
    .RSP_VALID (RSP_VALID),
    .RSP_DATA  (RSP_DATA),
    .RSP_OOR   (RSP_OOR),
    .RSP_RDY   (RSP_RDY),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_DOUT  (RAM_DOUT),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA)
  );

  assign RAM_DOUT = ram[RAM_ADDR];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: RAM contents plus an ordered list of owed responses, at most two.
  always @(posedge clk) begin
    exp_t e;
    bit   acc;
    bit   pop;
    if (!loaded) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'(i * 13 + 7);
      ram[1] <= 8'hA5;
      ram[3] <= 8'h11;
      loaded = 1'b1;
    end else begin
      if (RST) begin
        q.delete();
      end else begin
        acc    = REQ_VALID && (q.size() < 2);
        pop    = RSP_RDY && (q.size() > 0);
        e.oor  = (int'(REQ_ADDR) > HI);
        if (e.oor) e.data = '0;
        else if (BYPASS && WR_EN && (WR_ADDR == REQ_ADDR)) e.data = WR_DATA;
        else e.data = ram[REQ_ADDR];
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      if (WR_EN) ram[WR_ADDR] <= WR_DATA;
      started = 1'b1;
    end
  end

  // Every cycle after the first edges, DUT outputs must agree with the reference.
  always @(negedge clk) begin
    if (started) begin
      check("req_rdy", 32'(REQ_RDY), 32'(!RST && (q.size() < 2)));
      check("rsp_valid", 32'(RSP_VALID), 32'(q.size() > 0));
      check("ram_addr", 32'(RAM_ADDR), 32'(REQ_ADDR));
      if (q.size() > 0) begin
        check("rsp_data", 32'(RSP_DATA), 32'(q[0].data));
        check("rsp_oor", 32'(RSP_OOR), 32'(q[0].oor));
      end
    end
  end

  initial begin
    logic [AW-1:0] t2_addr [3];
    logic [DW-1:0] t2_data [3];
    t2_addr = '{5'd2, 5'd3, 5'd4};
    t2_data = '{8'h21, 8'h11, 8'h3B};
    n_cmp = 0; n_fail = 0; loaded = 1'b0; started = 1'b0;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; RSP_RDY = 1'b0;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    step(); step(); step();
    check("reset_valid", 32'(RSP_VALID), 32'd0);
    check("reset_data", 32'(RSP_DATA), 32'd0);
    check("reset_oor", 32'(RSP_OOR), 32'd0);
    check("reset_rdy", 32'(REQ_RDY), 32'd0);
    RST = 1'b0;
    step();
    check("post_reset_rdy", 32'(REQ_RDY), 32'd1);

    // single read, one-cycle latency
    REQ_VALID = 1'b1; REQ_ADDR = 5'd1;
    step();
    REQ_VALID = 1'b0;
    check("t1_valid", 32'(RSP_VALID), 32'd1);
    check("t1_data", 32'(RSP_DATA), 32'hA5);
    check("t1_oor", 32'(RSP_OOR), 32'd0);
    RSP_RDY = 1'b1;
    step();
    check("t1_drained", 32'(RSP_VALID), 32'd0);

    // back-to-back streaming
    for (int i = 0; i < 3; i++) begin
      REQ_VALID = 1'b1; REQ_ADDR = t2_addr[i];
      step();
      check("t2_data", 32'(RSP_DATA), 32'(t2_data[i]));
      check("t2_rdy", 32'(REQ_RDY), 32'd1);
    end
    REQ_VALID = 1'b0;
    step();
    check("t2_drained", 32'(RSP_VALID), 32'd0);

    // backpressure fills the FIFO
    RSP_RDY = 1'b0; REQ_VALID = 1'b1;
    REQ_ADDR = 5'd5; step();
    REQ_ADDR = 5'd6; step();
    REQ_ADDR = 5'd7; step();
    check("t3_full_rdy", 32'(REQ_RDY), 32'd0);
    check("t3_head", 32'(RSP_DATA), 32'h48);
    REQ_VALID = 1'b0; RSP_RDY = 1'b1;
    step();
    RSP_RDY = 1'b0;
    check("t3_rdy_back", 32'(REQ_RDY), 32'd1);
    check("t3_second", 32'(RSP_DATA), 32'h55);
    RSP_RDY = 1'b1;
    step(); step();
    check("t3_drained", 32'(RSP_VALID), 32'd0);

    // read during write
    RSP_RDY = 1'b0; REQ_VALID = 1'b1; REQ_ADDR = 5'd3;
    WR_EN = 1'b1; WR_ADDR = 5'd3; WR_DATA = 8'h5C;
    step();
    REQ_VALID = 1'b0; WR_EN = 1'b0;
    check("t4_rdw", 32'(RSP_DATA), BYPASS ? 32'h5C : 32'h11);
    RSP_RDY = 1'b1;
    step();

    // out-of-range address
    RSP_RDY = 1'b0; REQ_VALID = 1'b1; REQ_ADDR = 5'd20;
    step();
    REQ_VALID = 1'b0;
    check("t5_oor", 32'(RSP_OOR), 32'd1);
    check("t5_data", 32'(RSP_DATA), 32'd0);
    RSP_RDY = 1'b1;
    step();

    // reset with responses pending
    RSP_RDY = 1'b0; REQ_VALID = 1'b1;
    REQ_ADDR = 5'd8; step();
    REQ_ADDR = 5'd9; step();
    REQ_VALID = 1'b0;
    check("t6_pending", 32'(RSP_VALID), 32'd1);
    RST = 1'b1;
    step();
    check("t6_rst_valid", 32'(RSP_VALID), 32'd0);
    check("t6_rst_rdy", 32'(REQ_RDY), 32'd0);
    RST = 1'b0;
    step();
    check("t6_after_rdy", 32'(REQ_RDY), 32'd1);
    check("t6_after_valid", 32'(RSP_VALID), 32'd0);
    REQ_VALID = 1'b1; REQ_ADDR = 5'd10;
    step();
    REQ_VALID = 1'b0;
    check("t6_own_data", 32'(RSP_DATA), 32'h89);
    RSP_RDY = 1'b1;
    step();
    check("t6_only_one", 32'(RSP_VALID), 32'd0);

    // mixed traffic against the reference
    for (int i = 0; i < 80; i++) begin
      REQ_VALID = 1'($urandom_range(0, 1));
      REQ_ADDR  = AW'($urandom_range(0, 31));
      RSP_RDY   = ($urandom_range(0, 3) != 0);
      WR_EN     = 1'($urandom_range(0, 1));
      WR_ADDR   = ($urandom_range(0, 1) != 0) ? REQ_ADDR : AW'($urandom_range(0, 31));
      WR_DATA   = DW'($urandom_range(0, 255));
      step();
    end
    REQ_VALID = 1'b0; WR_EN = 1'b0; RSP_RDY = 1'b1;
    step(); step(); step();
    check("final_drained", 32'(RSP_VALID), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
